mac_mode_sequencer: RTL and testbench
=====================================

Name: mac_mode_sequencer

Overview:
Sequences the MAC datapath (multiplier array, combiner, accumulators) and owns its configuration word. It gates operand issue with a valid/ready handshake and marks accumulation boundaries with a one-cycle accumulator clear. It tracks in-flight operations through the fixed-latency datapath and raises out_valid when a result reaches the combiner output. Mode changes (single/dual/quad, accumulate/multiply-only) are applied only at an accumulation boundary, after the pipeline has drained.

Parameters:
MAC_CONF_WIDTH, 3, config word width; [1:0] mode per mac_const.vh, [2] 1=accumulate, 0=multiply-only
MAC_PIPE_DEPTH, 2, cycles from issue (mac_en) to valid combiner output; legal values are 1 and above
CNT_WIDTH, 16, width of the per-accumulation operation counter
RST_CFG, 3'b100, mac_cfg value after reset (single, accumulate)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
op_valid  in  1  upstream operand valid
op_last  in  1  final operand of current accumulation; qualified by op_valid
op_ready  out  1  sequencer accepts operand
cfg_req_valid  in  1  reconfiguration request
cfg_req  in  MAC_CONF_WIDTH  requested config word
cfg_req_ready  out  1  request accepted
mac_en  out  1  datapath issue enable (= op_valid & op_ready)
acc_clr  out  1  accumulator loads instead of adding this cycle
mac_cfg  out  MAC_CONF_WIDTH  registered config driven to combiner/accumulators
out_valid  out  1  combiner output holds a complete result
out_count  out  CNT_WIDTH  number of ops folded into the result; valid with out_valid
busy  out  1  state != RUN, or any op in flight
err_cfg  out  1  one-cycle pulse when an illegal mode (cfg_req[1:0]==2'b11) is accepted and dropped

Behaviour:
- Reset (rst low, asynchronous): state=RUN, mac_cfg=RST_CFG, first=1, cnt=0, pipe valid/last bits=0. op_ready, cfg_req_ready, mac_en, acc_clr, out_valid, err_cfg and busy all =0. out_count=0. Reset mid-DRAIN discards the pending config and all in-flight ops.
- FSM states are RUN, DRAIN and SWITCH.
- RUN:
  - op_ready=1 unless cfg_req_ready&cfg_req_valid this cycle.
  - cfg_req_ready=1 only when first=1 (no accumulation open).
  - A request accepted with a legal mode latches pend_cfg, drops op_ready in the same cycle and moves to DRAIN. The cfg request wins over a simultaneous op_valid.
  - A request with an illegal mode is accepted: err_cfg pulses for one cycle and the state stays RUN.
- DRAIN: op_ready=0, cfg_req_ready=0. Moves to SWITCH in the cycle after all pipe valid bits are 0.
- SWITCH: lasts one cycle. mac_cfg<=pend_cfg, first<=1, then return to RUN. First issue under the new config occurs no earlier than the cycle after SWITCH.
- Accumulate mode (mac_cfg[2]=1):
  - acc_clr = mac_en & first.
  - first<=op_last on each issue.
  - cnt<=first?1:cnt+1 on each issue. cnt saturates at all-ones and does not wrap.
  - The pipe carries {valid, last, cnt_next}. out_valid is asserted when a last=1 entry exits the pipe, exactly MAC_PIPE_DEPTH cycles after the issue of the op_last op. out_count is the carried cnt.
- Multiply-only mode (mac_cfg[2]=0):
  - acc_clr = mac_en on every issue.
  - op_last is ignored and first stays 1.
  - Every issue produces out_valid MAC_PIPE_DEPTH cycles later, with out_count=1.
- Back-to-back issue is supported: throughput is 1 op/cycle and there are no bubbles between accumulations.
- op_valid without op_ready is held by upstream. op_last is sampled only on mac_en.
- mac_cfg changes only in SWITCH and is never changed while a valid bit is in the pipe.

Decomposition:
- mac_const.vh (existing shared include) holds:
  - MAC_SINGLE=2'b00, MAC_DUAL=2'b01, MAC_QUAD=2'b10
  - new defines MAC_CFG_ACC_BIT=2 and MAC_MODE_ILLEGAL=2'b11
  - state encodings SEQ_RUN, SEQ_DRAIN, SEQ_SWITCH
- One sub-module: mac_valid_pipe. It is a MAC_PIPE_DEPTH-stage shift register of {valid, last, count}, with an asynchronous active-low clear, an empty flag and a tail output. The FSM, counter and handshake logic stay in mac_mode_sequencer.

Test Plan:
- Reset, then 4 ops with op_last on the 4th, in accumulate mode with MAC_PIPE_DEPTH=2 → acc_clr only on op 1; out_valid exactly 2 cycles after op 4 issue; out_count=4.
- Two back-to-back 3-op accumulations with no gap → acc_clr on ops 1 and 4; out_valid 2 cycles after ops 3 and 6, each with out_count=3; op_ready held at 1 throughout.
- cfg_req=3'b010 asserted mid-accumulation (after op 2 of 4) → cfg_req_ready=0 until op 4 issued. Then DRAIN for 2 cycles, SWITCH, mac_cfg=3'b010; busy=1 from acceptance through SWITCH.
- cfg_req_valid and op_valid simultaneous at a boundary with cfg_req=3'b001 → request accepted, op_ready=0 and mac_en=0 that cycle; the op issues after SWITCH with acc_clr=1.
- cfg_req=3'b111 → accepted, err_cfg pulses one cycle, mac_cfg unchanged, no DRAIN entered.
- Multiply-only mode (mac_cfg=3'b000), 5 consecutive ops → 5 acc_clr pulses and 5 out_valid pulses, each with out_count=1. Assert rst low during the 3rd op → all outputs 0 immediately; no out_valid after release until new ops issue.

Source files
------------

// File: rtl/mac_mode_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_mode_sequencer_pkg
// Description : Shared constants, state type and helpers for the MAC
//               mode sequencer and its valid-tracking pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_mode_sequencer_pkg;

  // Combiner mode encodings carried in cfg[1:0]
  localparam logic [1:0] MAC_SINGLE       = 2'b00;
  localparam logic [1:0] MAC_DUAL         = 2'b01;
  localparam logic [1:0] MAC_QUAD         = 2'b10;
  localparam logic [1:0] MAC_MODE_ILLEGAL = 2'b11;

  // cfg bit selecting accumulate (1) versus multiply-only (0)
  localparam int MAC_CFG_ACC_BIT = 2;

  // Sequencer states
  typedef enum logic [1:0] {
    SEQ_RUN    = 2'd0,
    SEQ_DRAIN  = 2'd1,
    SEQ_SWITCH = 2'd2
  } seq_state_t;

  // A mode field is usable unless it is the reserved encoding
  function automatic logic mode_is_legal(input logic [1:0] mode);
    return (mode != MAC_MODE_ILLEGAL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mac_valid_pipe
// Description : Shift register that shadows the fixed-latency MAC datapath,
//               carrying {valid, last, count} for each issued op. Provides
//               the exiting (tail) entry and an empty flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_valid_pipe #(
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [CNT_WIDTH-1:0] in_cnt,
  output logic                 tail_valid,
  output logic                 tail_last,
  output logic [CNT_WIDTH-1:0] tail_cnt,
  output logic                 empty
);

  logic [DEPTH-1:0]     stage_valid;
  logic [DEPTH-1:0]     stage_last;
  logic [CNT_WIDTH-1:0] stage_cnt [DEPTH];

  // Advance every entry one stage per cycle; idle slots carry zeros
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_valid <= '0;
      stage_last  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stage_cnt[i] <= '0;
      end
    end else begin
      stage_valid[0] <= in_valid;
      stage_last[0]  <= in_valid & in_last;
      stage_cnt[0]   <= in_valid ? in_cnt : '0;
      for (int i = 1; i < DEPTH; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_last[i]  <= stage_last[i-1];
        stage_cnt[i]   <= stage_cnt[i-1];
      end
    end
  end

  // Tail is the entry leaving the datapath this cycle
  always_comb begin
    tail_valid = stage_valid[DEPTH-1];
    tail_last  = stage_last[DEPTH-1];
    tail_cnt   = stage_cnt[DEPTH-1];
    empty      = ~|stage_valid;
  end

endmodule
`default_nettype wire

// File: rtl/mac_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mac_mode_sequencer
// Description : Issues operands into the MAC datapath, marks accumulation
//               boundaries with acc_clr, tracks in-flight ops to raise
//               out_valid, and applies configuration changes only at an
//               accumulation boundary once the datapath has drained.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_mode_sequencer
  import mac_mode_sequencer_pkg::*;
#(
  parameter int                        MAC_CONF_WIDTH = 3,
  parameter int                        MAC_PIPE_DEPTH = 2,
  parameter int                        CNT_WIDTH      = 16,
  parameter logic [MAC_CONF_WIDTH-1:0] RST_CFG        = 3'b100
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      op_valid,
  input  logic                      op_last,
  output logic                      op_ready,
  input  logic                      cfg_req_valid,
  input  logic [MAC_CONF_WIDTH-1:0] cfg_req,
  output logic                      cfg_req_ready,
  output logic                      mac_en,
  output logic                      acc_clr,
  output logic [MAC_CONF_WIDTH-1:0] mac_cfg,
  output logic                      out_valid,
  output logic [CNT_WIDTH-1:0]      out_count,
  output logic                      busy,
  output logic                      err_cfg
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  seq_state_t                state;
  seq_state_t                state_next;
  logic [MAC_CONF_WIDTH-1:0] pend_cfg;
  logic                      first;
  logic [CNT_WIDTH-1:0]      cnt;
  logic [CNT_WIDTH-1:0]      cnt_next;

  logic                      acc_mode;
  logic                      cfg_legal;
  logic                      cfg_accept;
  logic                      cfg_ready_raw;
  logic                      op_ready_raw;
  logic                      pipe_last;
  logic [CNT_WIDTH-1:0]      pipe_cnt;

  logic                      tail_valid;
  logic                      tail_last;
  logic [CNT_WIDTH-1:0]      tail_cnt;
  logic                      pipe_empty;

  // Next state plus handshake readies; a config request beats an operand
  always_comb begin
    state_next    = state;
    cfg_ready_raw = 1'b0;
    op_ready_raw  = 1'b0;
    unique case (state)
      SEQ_RUN: begin
        cfg_ready_raw = first;
        op_ready_raw  = ~(first & cfg_req_valid);
        if (cfg_accept && cfg_legal) begin
          state_next = SEQ_DRAIN;
        end
      end
      SEQ_DRAIN: begin
        if (pipe_empty) begin
          state_next = SEQ_SWITCH;
        end
      end
      SEQ_SWITCH: begin
        state_next = SEQ_RUN;
      end
      default: begin
        state_next = SEQ_RUN;
      end
    endcase
  end

  // Issue-side datapath controls; everything is forced low while in reset
  always_comb begin
    acc_mode      = mac_cfg[MAC_CFG_ACC_BIT];
    cfg_legal     = mode_is_legal(cfg_req[1:0]);
    cfg_req_ready = rst & cfg_ready_raw;
    op_ready      = rst & op_ready_raw;
    cfg_accept    = cfg_req_ready & cfg_req_valid;
    err_cfg       = cfg_accept & ~cfg_legal;
    mac_en        = op_valid & op_ready;
    // Multiply-only never opens an accumulation, so every issue loads
    acc_clr       = mac_en & (first | ~acc_mode);
    if (first) begin
      cnt_next = CNT_ONE;
    end else if (&cnt) begin
      cnt_next = cnt;
    end else begin
      cnt_next = cnt + CNT_ONE;
    end
    pipe_last = acc_mode ? op_last : 1'b1;
    pipe_cnt  = acc_mode ? cnt_next : CNT_ONE;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SEQ_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Config holding: capture a legal request, commit it only in SWITCH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mac_cfg  <= RST_CFG;
      pend_cfg <= RST_CFG;
    end else begin
      if (cfg_accept && cfg_legal) begin
        pend_cfg <= cfg_req;
      end
      if (state == SEQ_SWITCH) begin
        mac_cfg <= pend_cfg;
      end
    end
  end

  // Accumulation boundary tracking and saturating op counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first <= 1'b1;
      cnt   <= '0;
    end else if (state == SEQ_SWITCH) begin
      first <= 1'b1;
    end else if (mac_en) begin
      first <= acc_mode ? op_last : 1'b1;
      cnt   <= pipe_cnt;
    end
  end

  mac_valid_pipe #(
    .DEPTH     (MAC_PIPE_DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_valid_pipe (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (mac_en),
    .in_last    (pipe_last),
    .in_cnt     (pipe_cnt),
    .tail_valid (tail_valid),
    .tail_last  (tail_last),
    .tail_cnt   (tail_cnt),
    .empty      (pipe_empty)
  );

  // Result presentation and activity indication
  always_comb begin
    out_valid = rst & tail_valid & tail_last;
    out_count = out_valid ? tail_cnt : '0;
    busy      = rst & ((state != SEQ_RUN) | ~pipe_empty);
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_mode_sequencer
// Description : Randomized and directed stimulus against a cycle-count
//               reference model; results are checked by a scoreboard
//               monitor decoupled from the driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_mode_sequencer;

  localparam int              W       = 3;
  localparam int              D       = 2;
  localparam int              CW      = 16;
  localparam logic [W-1:0]    RST_CFG = 3'b100;
  localparam int              CNT_MAX = 65535;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          op_valid = 1'b0;
  logic          op_last = 1'b0;
  logic          cfg_req_valid = 1'b0;
  logic [W-1:0]  cfg_req = '0;
  logic          op_ready;
  logic          cfg_req_ready;
  logic          mac_en;
  logic          acc_clr;
  logic [W-1:0]  mac_cfg;
  logic          out_valid;
  logic [CW-1:0] out_count;
  logic          busy;
  logic          err_cfg;

  mac_mode_sequencer #(
    .MAC_CONF_WIDTH (W),
    .MAC_PIPE_DEPTH (D),
    .CNT_WIDTH      (CW),
    .RST_CFG        (RST_CFG)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .op_valid      (op_valid),
    .op_last       (op_last),
    .op_ready      (op_ready),
    .cfg_req_valid (cfg_req_valid),
    .cfg_req       (cfg_req),
    .cfg_req_ready (cfg_req_ready),
    .mac_en        (mac_en),
    .acc_clr       (acc_clr),
    .mac_cfg       (mac_cfg),
    .out_valid     (out_valid),
    .out_count     (out_count),
    .busy          (busy),
    .err_cfg       (err_cfg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  int errors = 0;
  int checks = 0;

  typedef struct {
    int due;
    int count;
  } exp_t;
  exp_t sbq[$];

  // Reference model: configuration, open-accumulation flag, running count,
  // cycle of the latest issue and the cycle normal operation resumes.
  logic [W-1:0] m_cfg;
  logic [W-1:0] m_pend;
  bit           m_pending;
  bit           m_first;
  int           m_cnt;
  int           m_last_issue;
  int           m_run_from;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_cfg        = RST_CFG;
    m_pend       = RST_CFG;
    m_pending    = 1'b0;
    m_first      = 1'b1;
    m_cnt        = 0;
    m_last_issue = -100;
    m_run_from   = 0;
  endtask

  // Predict this cycle's outputs, compare, then advance the model
  task automatic evaluate(output bit issued);
    int n;
    bit run, cfg_rdy, acc_cfg, ordy, men, accm, clr, err, bsy;
    int drain_done;
    exp_t e;
    n = cyc;
    if (m_pending && n >= m_run_from) begin
      m_cfg     = m_pend;
      m_first   = 1'b1;
      m_pending = 1'b0;
    end
    run     = (n >= m_run_from);
    cfg_rdy = run && m_first;
    acc_cfg = cfg_rdy && cfg_req_valid;
    ordy    = run && !acc_cfg;
    men     = op_valid && ordy;
    accm    = m_cfg[2];
    clr     = men && (accm ? m_first : 1'b1);
    err     = acc_cfg && (cfg_req[1:0] == 2'b11);
    bsy     = !run || (n <= m_last_issue + D);

    chk("op_ready", op_ready, ordy);
    chk("cfg_req_ready", cfg_req_ready, cfg_rdy);
    chk("mac_en", mac_en, men);
    chk("acc_clr", acc_clr, clr);
    chk("err_cfg", err_cfg, err);
    chk("busy", busy, bsy);
    chk("mac_cfg", mac_cfg, m_cfg);

    if (men) begin
      if (accm) begin
        m_cnt = m_first ? 1 : ((m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1);
        if (op_last) begin
          e.due = n + D; e.count = m_cnt; sbq.push_back(e);
        end
        m_first = op_last;
      end else begin
        e.due = n + D; e.count = 1; sbq.push_back(e);
      end
      m_last_issue = n;
    end
    if (acc_cfg && cfg_req[1:0] != 2'b11) begin
      m_pend     = cfg_req;
      m_pending  = 1'b1;
      drain_done = (n + 1 > m_last_issue + D + 1) ? n + 1 : m_last_issue + D + 1;
      m_run_from = drain_done + 2;
    end
    issued = men;
  endtask

  task automatic step(input bit ov, input bit ol, input bit cv,
                      input logic [W-1:0] cr, output bit issued);
    @(posedge clk); #1;
    op_valid      = ov;
    op_last       = ol;
    cfg_req_valid = cv;
    cfg_req       = cr;
    @(negedge clk);
    evaluate(issued);
  endtask

  task automatic check_reset_outputs();
    chk("rst_op_ready", op_ready, 0);
    chk("rst_cfg_req_ready", cfg_req_ready, 0);
    chk("rst_mac_en", mac_en, 0);
    chk("rst_acc_clr", acc_clr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_err_cfg", err_cfg, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mac_cfg", mac_cfg, RST_CFG);
  endtask

  // Assert reset in the middle of a cycle while an operand is offered
  task automatic reset_mid(input bit ov);
    @(posedge clk); #1;
    op_valid      = ov;
    op_last       = 1'b0;
    cfg_req_valid = 1'b0;
    rst           = 1'b0;
    #1;
    check_reset_outputs();
    sbq.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    op_valid = 1'b0;
    rst      = 1'b1;
  endtask

  // Scoreboard monitor: every result must match the oldest prediction
  initial forever begin
    bit exp_ov;
    exp_t e;
    @(negedge clk);
    if (rst) begin
      exp_ov = (sbq.size() > 0) && (sbq[0].due == cyc);
      chk("out_valid", out_valid, exp_ov);
      if (out_valid && sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("out_cycle", cyc, e.due);
        chk("out_count", out_count, e.count);
      end else if (!out_valid && sbq.size() > 0 && sbq[0].due <= cyc) begin
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    bit iss;
    bit pov;
    bit pol;
    model_reset();
    #12;
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b1;

    // One 4-op accumulation in the reset config
    for (int i = 0; i < 4; i++) step(1'b1, i == 3, 1'b0, '0, iss);
    repeat (4) step(1'b0, 1'b0, 1'b0, '0, iss);

    // Two 3-op accumulations back to back
    for (int i = 0; i < 6; i++) step(1'b1, (i % 3) == 2, 1'b0, '0, iss);
    repeat (4) step(1'b0, 1'b0, 1'b0, '0, iss);

    // Reconfig requested mid-accumulation, held until accepted
    step(1'b1, 1'b0, 1'b0, '0, iss);
    step(1'b1, 1'b0, 1'b0, '0, iss);
    step(1'b1, 1'b0, 1'b1, 3'b010, iss);
    step(1'b1, 1'b1, 1'b1, 3'b010, iss);
    step(1'b0, 1'b0, 1'b1, 3'b010, iss);
    repeat (6) step(1'b0, 1'b0, 1'b0, '0, iss);

    // Reconfig and operand together at a boundary; operand waits
    step(1'b1, 1'b0, 1'b1, 3'b001, iss);
    chk("collide_no_issue", iss, 0);
    iss = 1'b0;
    for (int k = 0; k < 20 && !iss; k++) step(1'b1, 1'b0, 1'b0, '0, iss);
    chk("collide_issue_bound", iss, 1);
    repeat (4) step(1'b0, 1'b0, 1'b0, '0, iss);

    // Illegal mode request
    step(1'b0, 1'b0, 1'b1, 3'b111, iss);
    repeat (3) step(1'b0, 1'b0, 1'b0, '0, iss);

    // Multiply-only, five consecutive ops
    step(1'b0, 1'b0, 1'b1, 3'b000, iss);
    repeat (6) step(1'b0, 1'b0, 1'b0, '0, iss);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, '0, iss);
    repeat (4) step(1'b0, 1'b0, 1'b0, '0, iss);

    // Reset during the third op of a new burst; in-flight ops are dropped
    step(1'b1, 1'b0, 1'b0, '0, iss);
    step(1'b1, 1'b0, 1'b0, '0, iss);
    reset_mid(1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b0, '0, iss);

    // Randomized traffic with upstream holding unaccepted operands
    pov = 1'b0; pol = 1'b0; iss = 1'b0;
    for (int k = 0; k < 400; k++) begin
      bit ov, ol, cv;
      logic [W-1:0] cr;
      if (pov && !iss) begin
        ov = 1'b1; ol = pol;
      end else begin
        ov = ($urandom_range(0, 9) < 7);
        ol = ($urandom_range(0, 3) == 0);
      end
      cv = ($urandom_range(0, 19) == 0);
      cr = W'($urandom_range(0, 7));
      step(ov, ol, cv, cr, iss);
      pov = ov; pol = ol;
    end
    repeat (10) step(1'b0, 1'b0, 1'b0, '0, iss);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
